// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg : shared state encoding and sizing helper for seq_shift_add_mult
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must be able to hold WIDTH itself (reported during DONE).
  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_shift_add_datapath.sv
// ---------------------------------------------------------------------------
// seq_shift_add_datapath : accumulator, shifted multiplicand/multiplier regs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_shift_add_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   acc_sum,
`ifdef MULT_EARLY_TERM_EN
  output logic                 mplier_shift_zero,
`endif
  output logic                 next_bit
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
  assign next_bit = mplier_q[0];

`ifdef MULT_EARLY_TERM_EN
  // True when the value about to be shifted in has no set bits left.
  assign mplier_shift_zero = ~|mplier_q[WIDTH-1:1];
`endif

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, multiplicand};
      mplier_d = multiplier;
    end else if (step) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_shift_add_mult.sv
// ---------------------------------------------------------------------------
// seq_shift_add_mult : sequential shift-and-add unsigned multiplier with
// start/ready/valid handshake. Optional macro MULT_EARLY_TERM_EN ends the
// iteration as soon as no multiplier bits remain.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter  int WIDTH = 3,
  localparam int CW    = calc_cw(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   product,
  output logic                 next_bit,
  output logic [CW-1:0]        count_out
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               dp_load, dp_step;
  logic               last_iter;
  logic [2*WIDTH-1:0] acc_sum;

`ifdef MULT_EARLY_TERM_EN
  logic mplier_shift_zero;
  assign last_iter = (count_q == CW'(WIDTH - 1)) || mplier_shift_zero;
`else
  assign last_iter = (count_q == CW'(WIDTH - 1));
`endif

  seq_shift_add_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk              (clk),
    .reset            (reset),
    .load             (dp_load),
    .step             (dp_step),
    .multiplicand     (multiplicand),
    .multiplier       (multiplier),
    .acc_sum          (acc_sum),
`ifdef MULT_EARLY_TERM_EN
    .mplier_shift_zero(mplier_shift_zero),
`endif
    .next_bit         (next_bit)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    product_d = product_q;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dp_load = 1'b1;
          count_d = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        dp_step = 1'b1;
        count_d = count_q + 1'b1;
        // acc_sum already includes this final iteration's partial product.
        if (last_iter) begin
          product_d = acc_sum;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign valid     = (state_q == ST_DONE);
  assign product   = product_q;
  assign count_out = count_q;

endmodule

`default_nettype wire

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Parametrised sequential shift-and-add unsigned multiplier.
- Next generation of the fixed 3-bit multiplier FSM. Operand width is generic.
- Internal control replaces the external s1/s2/en1/en2 strobes, with a start/ready/valid handshake.
- Sits between operand registers and the result bus. Produces one 2*WIDTH-bit product per accepted start.

Parameters:
WIDTH, 3, operand width in bits (>=2); product is 2*WIDTH bits
CW, $clog2(WIDTH+1), width of iteration counter (localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when ready=1
multiplicand  input  WIDTH  operand M, sampled on accepted start
multiplier  input  WIDTH  operand m, sampled on accepted start
ready  output  1  high only in IDLE
valid  output  1  one-cycle pulse; product holds new result
product  output  2*WIDTH  result register; holds value until next valid
next_bit  output  1  LSB of working multiplier register (bit being evaluated)
count_out  output  CW  iterations completed in current operation

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, valid=0, product=0, next_bit=0, count_out=0, all working registers=0.
- Working registers:
  - acc: 2*WIDTH bits.
  - mcand: 2*WIDTH bits, multiplicand zero-extended.
  - mplier: WIDTH bits.
- States: IDLE, CALC, DONE.
- IDLE:
  - ready=1.
  - On start=1: load mcand, load mplier, set acc=0 and count=0, go to CALC.
  - start=0: stay in IDLE.
- CALC (ready=0), each cycle:
  - If mplier[0]: acc <= acc + mcand (2*WIDTH bits, cannot overflow).
  - mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1.
  - When count reaches WIDTH-1 (last iteration), go to DONE.
- DONE:
  - product <= final acc (registered on DONE entry).
  - valid=1 for exactly this cycle; ready=0.
  - Next cycle: IDLE.
- Latency: start sampled at edge 0; valid high in the cycle after edge WIDTH. That is WIDTH+1 cycles; next start can be accepted WIDTH+2 cycles after the previous one.
- start while ready=0 is ignored entirely; no queuing.
- Operands may change freely after acceptance without effect.
- next_bit = mplier[0] combinationally from the register; reads 0 in IDLE after reset.
- count_out:
  - equals count;
  - holds WIDTH during DONE;
  - clears to 0 on the next acceptance.
- Zero operands: full WIDTH iterations, product=0.
- All-ones: (2^WIDTH-1)^2, exact.

Optional Feature:
- Macro: MULT_EARLY_TERM_EN.
- Defined: in CALC, if the shifted mplier value becomes 0, go to DONE immediately after that iteration.
  - Latency = (index of highest set multiplier bit)+2 cycles; minimum 2 for multiplier=0.
  - count_out reports the iterations actually executed.
- Undefined: fixed WIDTH+1 latency as above; no zero-detect logic synthesised.
- Product value is identical in both builds.

Decomposition:
- Package mult_pkg:
  - state enum type (IDLE, CALC, DONE);
  - helper function for CW.
- Sub-module seq_shift_add_datapath: acc/mcand/mplier registers, adder, shifters.
- Top module holds the FSM, counter and handshake.

Test Plan:
1. WIDTH=3, reset 10ns then release; start with M=4, m=1 -> valid pulse 4 cycles later, product=6'd4, count_out=3, ready returns next cycle.
2. WIDTH=8, M=255, m=255 -> product=16'hFE01 at cycle 9; next_bit sequence 1,1,1,1,1,1,1,1 during CALC.
3. WIDTH=8, accept M=7, m=6; pulse start again at cycle 3 with M=9, m=9 -> second start ignored, product=42; start after ready=1 -> product=81.
4. Assert reset while count_out=3 -> same-edge (async) ready=1, valid=0, product=0, count_out=0; new start then gives a correct result.
5. WIDTH=8, m=0, M=200 -> product=0; latency 9 without macro, 2 with MULT_EARLY_TERM_EN; m=8'h01 gives latency 2, m=8'h80 gives latency 9, products correct.
6. Random sweep of 1000 operand pairs, WIDTH=3 (exhaustive) and WIDTH=8 -> product equals M*m, exactly one valid per accepted start, valid never high while ready=1.
